// File: rtl/oscp_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : oscp_bridge_pkg
// Description : Shared constants for the SDRAM bridge masters: default
//               bridge address/data widths, burstcount width and the
//               writer FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package oscp_bridge_pkg;

    localparam int c_addr_w = 26;   // bridge word-address width
    localparam int c_data_w = 16;   // bridge / FIFO data width
    localparam int c_bcnt_w = 10;   // Avalon burstcount width (max 512 beats)

    typedef logic [1:0] state_t;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_wait  = 2'd1;
    localparam logic [1:0] c_st_burst = 2'd2;
    localparam logic [1:0] c_st_fin   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/bridge_burst_calc.sv
`default_nettype none
// ============================================================================
// Module      : bridge_burst_calc
// Description : Combinational burst sizing for the SDRAM bridge writer.
//               o_blen          = min(BURST_LEN, i_remaining)
//               o_next_addr     = i_addr + i_burstcount      (mod 2^ADDR_W)
//               o_next_remaining= i_remaining - i_burstcount
// Ports       : i_remaining, i_addr, i_burstcount -> o_blen, o_next_addr,
//               o_next_remaining
// Revision    : 1.0 - initial release
// ============================================================================
module bridge_burst_calc
    import oscp_bridge_pkg::*;
#(
    parameter int ADDR_W    = c_addr_w,
    parameter int BURST_LEN = 128
) (
    input  logic [ADDR_W-1:0]   i_remaining,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [c_bcnt_w-1:0] i_burstcount,
    output logic [c_bcnt_w-1:0] o_blen,
    output logic [ADDR_W-1:0]   o_next_addr,
    output logic [ADDR_W-1:0]   o_next_remaining
);

    localparam logic [ADDR_W-1:0]   c_burst_len_a = ADDR_W'(BURST_LEN);
    localparam logic [c_bcnt_w-1:0] c_burst_len_b = c_bcnt_w'(BURST_LEN);

    // Below BURST_LEN the remaining count fits in the burstcount field.
    assign o_blen = (i_remaining >= c_burst_len_a) ? c_burst_len_b
                                                   : i_remaining[c_bcnt_w-1:0];

    assign o_next_addr      = i_addr + ADDR_W'(i_burstcount);
    assign o_next_remaining = i_remaining - ADDR_W'(i_burstcount);

endmodule
`default_nettype wire

// File: rtl/sdram_bridge_writer.sv
`default_nettype none
// ============================================================================
// Module      : sdram_bridge_writer
// Description : Avalon-MM burst-write master. Drains a show-ahead sink FIFO
//               into SDRAM through the sdram_bridge slave, one frame per
//               start pulse, in bursts of up to BURST_LEN beats.
// Ports       : clk, rst_n (async, active low)
//               start/abort pulses, base_addr/frame_len (sampled on start)
//               fifo_rdusedw/fifo_q/fifo_rdreq   - show-ahead sink FIFO
//               bridge_* - Avalon-MM burst write master
//               busy, done, aborted, frame_sel   - status
// Options     : `define PING_PONG_EN to alternate frames between base_addr
//               and base_addr + length; frame_sel reports the buffer just
//               completed. Otherwise frame_sel is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_bridge_writer
    import oscp_bridge_pkg::*;
#(
    parameter int ADDR_W      = c_addr_w,
    parameter int DATA_W      = c_data_w,
    parameter int BURST_LEN   = 128,
    parameter int FRAME_WORDS = 384000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W-1:0]   frame_len,
    input  logic [9:0]          fifo_rdusedw,
    input  logic [DATA_W-1:0]   fifo_q,
    output logic                fifo_rdreq,
    output logic [ADDR_W-1:0]   bridge_address,
    output logic [c_bcnt_w-1:0] bridge_burstcount,
    output logic                bridge_write,
    output logic [DATA_W-1:0]   bridge_writedata,
    input  logic                bridge_waitrequest,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic                frame_sel
);

    localparam logic [ADDR_W-1:0] c_frame_words = ADDR_W'(FRAME_WORDS);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_remaining;
    logic [ADDR_W-1:0]   r_bridge_address;
    logic [c_bcnt_w-1:0] r_burstcount;
    logic [c_bcnt_w-1:0] r_beat;
    logic                r_write;
    logic                r_busy;
    logic                r_done;
    logic                r_aborted;
    logic                r_abort_pend;

    logic [ADDR_W-1:0]   w_len;
    logic [ADDR_W-1:0]   w_start_base;
    logic [ADDR_W-1:0]   w_next_addr;
    logic [ADDR_W-1:0]   w_next_rem;
    logic [c_bcnt_w-1:0] w_blen;
    logic                w_accept;
    logic                w_last_beat;
    logic                w_abort_req;

    assign w_len = (frame_len == '0) ? c_frame_words : frame_len;

    bridge_burst_calc #(
        .ADDR_W    (ADDR_W),
        .BURST_LEN (BURST_LEN)
    ) u_burst_calc (
        .i_remaining      (r_remaining),
        .i_addr           (r_addr),
        .i_burstcount     (r_burstcount),
        .o_blen           (w_blen),
        .o_next_addr      (w_next_addr),
        .o_next_remaining (w_next_rem)
    );

    assign w_accept    = r_write & ~bridge_waitrequest;
    assign w_last_beat = w_accept & (r_beat == (r_burstcount - 1'b1));
    // An abort seen during a burst is held until the burst drains.
    assign w_abort_req = abort | r_abort_pend;

`ifdef PING_PONG_EN
    logic r_buf_sel;    // buffer the next frame will use
    logic r_cur_sel;    // buffer of the frame in progress
    logic r_frame_sel;

    assign w_start_base = r_buf_sel ? (base_addr + w_len) : base_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_sel   <= 1'b0;
            r_cur_sel   <= 1'b0;
            r_frame_sel <= 1'b0;
        end else if ((r_state == c_st_idle) && start) begin
            r_cur_sel <= r_buf_sel;
        end else if ((r_state == c_st_fin) && !r_aborted) begin
            // Aborted frames leave the buffer selection untouched so the
            // interrupted buffer is rewritten by the next frame.
            r_frame_sel <= r_cur_sel;
            r_buf_sel   <= ~r_cur_sel;
        end
    end

    assign frame_sel = r_frame_sel;
`else
    assign w_start_base = base_addr;
    assign frame_sel    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= c_st_idle;
            r_addr           <= '0;
            r_remaining      <= '0;
            r_bridge_address <= '0;
            r_burstcount     <= '0;
            r_beat           <= '0;
            r_write          <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_aborted        <= 1'b0;
            r_abort_pend     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_addr       <= w_start_base;
                        r_remaining  <= w_len;
                        r_busy       <= 1'b1;
                        r_aborted    <= 1'b0;
                        r_abort_pend <= 1'b0;
                        r_state      <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (w_abort_req) begin
                        r_aborted <= 1'b1;
                        r_state   <= c_st_fin;
                    end else if (fifo_rdusedw >= w_blen) begin
                        // Whole burst is already in the FIFO, so the burst
                        // can never stall on an empty FIFO mid-way.
                        r_bridge_address <= r_addr;
                        r_burstcount     <= w_blen;
                        r_beat           <= '0;
                        r_write          <= 1'b1;
                        r_state          <= c_st_burst;
                    end
                end
                c_st_burst: begin
                    if (abort) begin
                        r_abort_pend <= 1'b1;
                    end
                    if (w_accept) begin
                        r_beat <= r_beat + 1'b1;
                    end
                    if (w_last_beat) begin
                        r_write     <= 1'b0;
                        r_addr      <= w_next_addr;
                        r_remaining <= w_next_rem;
                        if (w_abort_req) begin
                            r_aborted <= 1'b1;
                            r_state   <= c_st_fin;
                        end else if (w_next_rem != '0) begin
                            r_state <= c_st_wait;
                        end else begin
                            r_state <= c_st_fin;
                        end
                    end
                end
                c_st_fin: begin
                    r_done       <= 1'b1;
                    r_busy       <= 1'b0;
                    r_abort_pend <= 1'b0;
                    r_state      <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign fifo_rdreq        = w_accept;
    assign bridge_address    = r_bridge_address;
    assign bridge_burstcount = r_burstcount;
    assign bridge_write      = r_write;
    // Gated so the data bus idles at zero outside a burst and in reset.
    assign bridge_writedata  = r_write ? fifo_q : '0;
    assign busy              = r_busy;
    assign done              = r_done;
    assign aborted           = r_aborted;

endmodule
`default_nettype wire

// File: tb/tb_sdram_bridge_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_bridge_writer
// Description : Directed self-checking bench for sdram_bridge_writer with a
//               show-ahead FIFO model and an Avalon write monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_bridge_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [25:0] base_addr = '0;
    logic [25:0] frame_len = '0;
    logic [9:0]  fifo_rdusedw;
    logic [15:0] fifo_q;
    logic        fifo_rdreq;
    logic [25:0] bridge_address;
    logic [9:0]  bridge_burstcount;
    logic        bridge_write;
    logic [15:0] bridge_writedata;
    logic        bridge_waitrequest = 1'b0;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        frame_sel;

    always #5 clk = ~clk;

    sdram_bridge_writer #(
        .ADDR_W      (26),
        .DATA_W      (16),
        .BURST_LEN   (128),
        .FRAME_WORDS (200)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .abort              (abort),
        .base_addr          (base_addr),
        .frame_len          (frame_len),
        .fifo_rdusedw       (fifo_rdusedw),
        .fifo_q             (fifo_q),
        .fifo_rdreq         (fifo_rdreq),
        .bridge_address     (bridge_address),
        .bridge_burstcount  (bridge_burstcount),
        .bridge_write       (bridge_write),
        .bridge_writedata   (bridge_writedata),
        .bridge_waitrequest (bridge_waitrequest),
        .busy               (busy),
        .done               (done),
        .aborted            (aborted),
        .frame_sel          (frame_sel)
    );

    // ---------------- show-ahead FIFO model ----------------
    logic [15:0] mem [0:4095];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          occ;
    logic [15:0] push_val = 16'd0;

    always_comb begin
        occ          = wr_ptr - rd_ptr;
        fifo_rdusedw = (occ > 1023) ? 10'd1023 : occ[9:0];
        fifo_q       = mem[rd_ptr[11:0]];
    end

    always @(posedge clk) if (fifo_rdreq) rd_ptr <= rd_ptr + 1;

    // ---------------- random backpressure ----------------
    logic bp_en = 1'b0;
    always @(negedge clk) bridge_waitrequest = bp_en ? 1'($urandom_range(0, 1)) : 1'b0;

    // ---------------- bus monitor ----------------
    int          cyc = 0, nb = 0, n_beats = 0, n_pops = 0, n_done = 0, viol = 0;
    int          t_start = 0, t_wr = 0, t_acc = 0, t_done = 0, beats_in = 0;
    logic        first_pend = 1'b0, prev_wr = 1'b0, stall_pend = 1'b0;
    logic [9:0]  prev_cnt = '0, h_cnt = '0;
    logic [25:0] h_addr = '0;
    logic [15:0] h_data = '0, exp_data = 16'd0;
    logic [25:0] b_addr [0:63];
    logic [9:0]  b_cnt  [0:63];
    logic        d_sel = 1'b0, d_abt = 1'b0;

    always @(posedge clk) begin
        if (start && !busy) begin
            t_start    = cyc;
            first_pend = 1'b1;
        end
        // a stalled beat must be presented again unchanged
        if (stall_pend && (bridge_write !== 1'b1 || bridge_address !== h_addr ||
                           bridge_burstcount !== h_cnt || bridge_writedata !== h_data))
            viol++;
        stall_pend = bridge_write && bridge_waitrequest;
        h_addr = bridge_address; h_cnt = bridge_burstcount; h_data = bridge_writedata;
        // write may only drop after the full burstcount was accepted
        if (prev_wr && !bridge_write && beats_in != int'(prev_cnt)) viol++;
        if (bridge_write && !prev_wr) begin
            b_addr[nb % 64] = bridge_address;
            b_cnt[nb % 64]  = bridge_burstcount;
            nb++;
            beats_in = 0;
            if (first_pend) begin t_wr = cyc; first_pend = 1'b0; end
        end
        if (bridge_write && !bridge_waitrequest) begin
            n_beats++; beats_in++;
            if (bridge_writedata !== exp_data) viol++;
            exp_data = exp_data + 16'd1;
            t_acc = cyc;
        end
        if (fifo_rdreq) n_pops++;
        if (done) begin n_done++; t_done = cyc; d_sel = frame_sel; d_abt = aborted; end
        prev_wr = bridge_write; prev_cnt = bridge_burstcount;
        if (!rst_n) begin prev_wr = 1'b0; stall_pend = 1'b0; end
        cyc++;
    end

    // ---------------- checking helpers ----------------
    int n_checks = 0, n_pass = 0, n_fail = 0;
    int m_nb, m_beats, m_pops, m_done, t_mark;
    logic        pp_next = 1'b0, last_sel = 1'b0, cur_buf = 1'b0;
    logic [25:0] cur_base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[11:0]] = push_val;
            push_val = push_val + 16'd1;
            wr_ptr++;
        end
    endtask

    task automatic frame_begin(input logic [25:0] b, input logic [25:0] l);
        logic [25:0] len;
        m_nb = nb; m_beats = n_beats; m_pops = n_pops; m_done = n_done;
        len = (l == 26'd0) ? 26'd200 : l;
`ifdef PING_PONG_EN
        cur_buf = pp_next;
`else
        cur_buf = 1'b0;
`endif
        cur_base = cur_buf ? (b + len) : b;
        base_addr = b; frame_len = l; start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int k = 0;
        while (n_done == m_done && k < bound) begin tick(1); k++; end
        chk({tag, "_done"}, n_done - m_done, 1);
    endtask

    task automatic sel_check(input string tag, input logic abt);
        chk({tag, "_aborted"}, d_abt, abt);
        chk({tag, "_sel"}, d_sel, abt ? last_sel : cur_buf);
        if (!abt) begin last_sel = cur_buf; pp_next = ~cur_buf; end
    endtask

    task automatic wait_beats(input int n);
        for (int k = 0; k < 3000 && (n_beats - m_beats) < n; k++) tick(1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [25:0] pp_addr [0:2];
        logic        pp_sel  [0:2];

        // reset state
        tick(3);
        chk("rst_write", bridge_write, 0);
        chk("rst_busy_done_abt_sel", {busy, done, aborted, frame_sel, fifo_rdreq}, 0);
        chk("rst_addr_cnt", {bridge_address, bridge_burstcount}, 0);
        rst_n = 1'b1;
        tick(2);

        // basic frame: 256 words, two full bursts; start mid-frame is ignored
        push(256);
        frame_begin(26'h0000100, 26'd256);
        tick(20);
        base_addr = 26'h0777; frame_len = 26'd5; start = 1'b1; tick(1); start = 1'b0;
        wait_done("basic", 2000);
        chk("basic_bursts", nb - m_nb, 2);
        chk("basic_addr0", b_addr[m_nb % 64], cur_base);
        chk("basic_addr1", b_addr[(m_nb + 1) % 64], cur_base + 26'd128);
        chk("basic_cnt", {b_cnt[m_nb % 64], b_cnt[(m_nb + 1) % 64]}, {10'd128, 10'd128});
        chk("basic_beats", n_beats - m_beats, 256);
        chk("basic_pops", n_pops - m_pops, 256);
        chk("basic_lat_start", t_wr - t_start, 2);
        chk("basic_lat_done", t_done - t_acc, 2);
        sel_check("basic", 1'b0);
        tick(1);
        chk("basic_idle", {busy, bridge_write}, 0);

        // short tail: 128 + 128 + 44
        push(300);
        frame_begin(26'h0002000, 26'd300);
        wait_done("tail", 3000);
        chk("tail_bursts", nb - m_nb, 3);
        chk("tail_cnt2", b_cnt[(m_nb + 2) % 64], 44);
        chk("tail_addr2", b_addr[(m_nb + 2) % 64], cur_base + 26'd256);
        chk("tail_beats", n_beats - m_beats, 300);
        sel_check("tail", 1'b0);

        // 50 % backpressure
        push(256);
        bp_en = 1'b1;
        frame_begin(26'h0003000, 26'd256);
        wait_done("bp", 5000);
        bp_en = 1'b0;
        chk("bp_bursts", nb - m_nb, 2);
        chk("bp_addr1", b_addr[(m_nb + 1) % 64], cur_base + 26'd128);
        chk("bp_beats", n_beats - m_beats, 256);
        chk("bp_pops", n_pops - m_pops, 256);
        sel_check("bp", 1'b0);

        // FIFO starvation: 100 words, burst waits for 128
        push(100);
        frame_begin(26'h0004000, 26'd128);
        tick(20);
        chk("starve_nowrite", {nb - m_nb, 31'(bridge_write)}, 0);
        chk("starve_busy", busy, 1);
        push(28);
        t_mark = cyc;
        wait_done("starve", 2000);
        chk("starve_lat", t_wr - t_mark, 1);
        chk("starve_cnt", b_cnt[m_nb % 64], 128);
        sel_check("starve", 1'b0);

        // frame_len 0 -> FRAME_WORDS (200), address wraps at 2^26
        push(200);
        frame_begin(26'h3FFFFC0, 26'd0);
        wait_done("wrap", 2000);
        chk("wrap_bursts", nb - m_nb, 2);
        chk("wrap_burst0", {b_addr[m_nb % 64], b_cnt[m_nb % 64]}, {cur_base, 10'd128});
        chk("wrap_burst1", {b_addr[(m_nb + 1) % 64], b_cnt[(m_nb + 1) % 64]},
            {cur_base + 26'd128, 10'd72});
        sel_check("wrap", 1'b0);

        // data ordering and Avalon burst rules across all traffic so far
        chk("stream_integrity", viol, 0);

        // abort during the first burst: burst completes, no second burst
        push(256);
        frame_begin(26'h0005000, 26'd256);
        wait_beats(10);
        abort = 1'b1; tick(1); abort = 1'b0;
        wait_done("abort", 2000);
        tick(5);
        chk("abort_bursts", nb - m_nb, 1);
        chk("abort_beats", n_beats - m_beats, 128);
        chk("abort_level", aborted, 1);
        sel_check("abort", 1'b1);

        // abort while waiting for data (remaining 128 words of FIFO used)
        frame_begin(26'h0006000, 26'd256);
        chk("abort_clr_on_start", aborted, 0);
        wait_beats(128);
        tick(3);
        chk("wabort_waiting", {busy, bridge_write}, 2'b10);
        abort = 1'b1; t_mark = cyc; tick(1); abort = 1'b0;
        wait_done("wabort", 100);
        chk("wabort_lat", t_done - t_mark, 2);
        chk("wabort_bursts", nb - m_nb, 1);
        sel_check("wabort", 1'b1);

        // ping-pong: three frames after a fresh reset
        rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(1);
        pp_next = 1'b0; last_sel = 1'b0;
`ifdef PING_PONG_EN
        pp_addr[0] = 26'h1000; pp_addr[1] = 26'h1040; pp_addr[2] = 26'h1000;
        pp_sel[0] = 1'b0; pp_sel[1] = 1'b1; pp_sel[2] = 1'b0;
`else
        pp_addr[0] = 26'h1000; pp_addr[1] = 26'h1000; pp_addr[2] = 26'h1000;
        pp_sel[0] = 1'b0; pp_sel[1] = 1'b0; pp_sel[2] = 1'b0;
`endif
        push(192);
        for (int f = 0; f < 3; f++) begin
            frame_begin(26'h0001000, 26'd64);
            wait_done("pp", 1000);
            chk("pp_addr", b_addr[m_nb % 64], pp_addr[f]);
            chk("pp_cnt", b_cnt[m_nb % 64], 64);
            chk("pp_sel", d_sel, pp_sel[f]);
            tick(1);
        end

        // reset mid-burst clears outputs at once
        push(128);
        frame_begin(26'h0000200, 26'd128);
        wait_beats(5);
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {bridge_write, busy, fifo_rdreq, done}, 0);
        chk("midrst_addr_cnt", {bridge_address, bridge_burstcount}, 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_bridge_writer.md
Name: sdram_bridge_writer

Overview:
Avalon-MM burst-write master that drains a show-ahead sink FIFO (16-bit words, e.g. captured frame or waveform data) into SDRAM through the sdram_bridge slave. It writes in the opposite direction to sdram_bridge_control, which reads SDRAM into the LCD FIFO. It sits in the 100 MHz Qsys clock domain. One frame is written per start pulse.

Parameters:
ADDR_W, 26, bridge word-address width
DATA_W, 16, bridge/FIFO data width
BURST_LEN, 128, maximum beats per burst (1..512)
FRAME_WORDS, 384000, default frame length in words (800x480)

Ports:
clk  in  1  system clock (100 MHz)
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin writing one frame
abort  in  1  one-cycle pulse; stop after the current burst
base_addr  in  ADDR_W  frame base word address, sampled on start
frame_len  in  ADDR_W  words in frame, sampled on start; 0 means use FRAME_WORDS
fifo_rdusedw  in  10  sink FIFO fill level
fifo_q  in  DATA_W  show-ahead FIFO head word
fifo_rdreq  out  1  FIFO pop
bridge_address  out  ADDR_W  burst start address
bridge_burstcount  out  10  beats in the current burst
bridge_write  out  1  Avalon write
bridge_writedata  out  DATA_W  write data
bridge_waitrequest  in  1  Avalon stall
busy  out  1  frame in progress
done  out  1  one-cycle pulse when the frame completes or aborts
aborted  out  1  level; last frame ended by abort, cleared on start
frame_sel  out  1  ping-pong buffer just completed (only with the optional feature)

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0.
- States and transitions:
  - IDLE: on start, latch base_addr and length (0 maps to FRAME_WORDS), set remaining = length, addr = base, busy = 1, clear aborted, then go to WAIT. start while busy is ignored.
  - WAIT: compute blen = min(BURST_LEN, remaining). When fifo_rdusedw >= blen, register bridge_address = addr and bridge_burstcount = blen, then go to BURST. A pending abort (see below) goes to FIN instead.
  - BURST: bridge_write = 1. bridge_writedata = fifo_q (combinational from the show-ahead head). A beat is accepted when bridge_write & ~bridge_waitrequest. fifo_rdreq equals the beat-accept signal. Address and burstcount stay stable for the whole burst. On the final beat accepted, add blen to addr, subtract blen from remaining, deassert write the next cycle, then go to WAIT if remaining > 0, otherwise FIN.
  - FIN: one cycle. done = 1, busy = 0, then return to IDLE.
- Beats are never dropped, and write is never deasserted mid-burst (this is an Avalon burst rule).
- abort:
  - In IDLE: ignored.
  - In WAIT: go to FIN next cycle with aborted = 1.
  - In BURST: latch an abort flag, finish the burst, then go to FIN with aborted = 1.
- The start and end of a burst are not both accepted in the same cycle. The end of the last burst plus a new start yields done, and the start is dropped.
- Address arithmetic is modulo 2^ADDR_W and wraps silently. The remaining counter is ADDR_W bits.
- Latency:
  - Start to first bridge_write: 2 cycles, provided the FIFO holds at least blen words.
  - Final beat to done: 2 cycles.
- rst_n asserted mid-burst: outputs clear immediately. The SDRAM controller tolerates the truncated burst. Software must re-issue start.

Optional Feature:
PING_PONG_EN. When defined, two base addresses are used: base_addr and base_addr + length. Each frame alternates between them, starting at the first buffer after reset. frame_sel holds the index of the buffer just completed and updates together with done; it is unchanged by an aborted frame. When undefined, every frame uses base_addr and frame_sel is tied to 0.

Decomposition:
- Shared package (oscp_bridge_pkg):
  - state encoding for IDLE, WAIT, BURST, FIN
  - ADDR_W and DATA_W constants
  - burstcount width (10)
- One sub-module, bridge_burst_calc: combinational min(BURST_LEN, remaining) plus the next-address/remaining update. Everything else stays in the top FSM.

Test Plan:
- Basic frame:
  - Stimulus: frame_len=256, BURST_LEN=128, FIFO prefilled with 0..255, no waitrequest.
  - Response: two bursts at addresses base and base+128, burstcount 128, data in order, 256 pops, one done.
- Short tail:
  - Stimulus: frame_len=300.
  - Response: bursts of 128, 128 and 44 beats; final address base+256; remaining reaches 0.
- Backpressure:
  - Stimulus: random waitrequest at 50%.
  - Response: write, address and data held while stalled; pops equal accepted beats exactly; data sequence intact.
- FIFO starvation:
  - Stimulus: rdusedw=100 with blen=128.
  - Response: stays in WAIT with no write; burst starts the cycle after rdusedw reaches 128.
- Abort mid-burst:
  - Stimulus: abort at beat 10 of the first burst.
  - Response: all 128 beats still complete; then done with aborted=1; no second burst.
- PING_PONG_EN:
  - Stimulus: three frames with len=64 and base=0x1000.
  - Response: bursts at 0x1000, then 0x1040, then 0x1000; frame_sel reads 0, 1, 0 at each done.
